// File: rtl/aes_round_pipe.sv
// aes_round_pipe
//   One AES encryption round on a 128-bit state, pipelined behind a
//   valid/ready handshake. Each block carries an opaque tag that comes back
//   with its result.
//
//   Parameters
//     PIPE_STAGES  register stages: 1 = whole round in one stage,
//                  2 = SubBytes/ShiftRows | MixColumns/AddRoundKey.
//                  Any value other than 1 builds the 2-stage version.
//     TAG_W        sideband tag width
//
//   Ports
//     clk, rst_n            clock, async active-low reset
//     flush                 synchronous drop of every in-flight block
//     in_valid/in_ready     input handshake
//     in_data, in_key       AES state (byte 0 at [127:120]) and round key
//     in_type               00 INIT, 01 MID, 10 FINAL, 11 reserved (runs as MID)
//     in_tag                sideband returned with the result
//     out_valid/out_ready   output handshake
//     out_data, out_tag     round result and its tag
//     occupancy             number of valid stages
//     err_type              sticky: a reserved-type block was accepted
module aes_round_pipe #(
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [127:0]     in_key,
  input  logic [1:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy,
  output logic             err_type
);

  // Element 0 is the most significant byte, matching the byte-0-at-MSB layout.
  typedef logic [0:15][7:0] state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // State is column-major: byte index = row + 4*col.
  function automatic state_t sub_shift(input state_t s);
    state_t r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[row + 4*c] = SBOX[s[row + 4*((c + row) % 4)]];
      end
    end
    return r;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c + 1];
      a2 = s[4*c + 2];
      a3 = s[4*c + 3];
      r[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // First half of the round: INIT bypasses the S-box layer.
  function automatic logic [127:0] pre_fn(input state_t d, input logic [1:0] t);
    return (t == 2'b00) ? d : sub_shift(d);
  endfunction

  // Second half: MixColumns for MID and reserved (type bit 0 set), then key.
  function automatic logic [127:0] post_fn(input state_t p, input logic [127:0] k,
                                           input logic mix);
    state_t m;
    m = mix ? mix_columns(p) : p;
    return m ^ k;
  endfunction

  logic       run_q;     // low until the first edge after reset release
  logic       in_fire;
  logic       out_fire;
  logic [1:0] occ_q;
  logic       err_q;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = occ_q;
  assign err_type  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      occ_q <= 2'd0;
      err_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (flush) begin
        occ_q <= 2'd0;
      end else begin
        case ({in_fire, out_fire})
          2'b10:   occ_q <= occ_q + 2'd1;
          2'b01:   occ_q <= occ_q - 2'd1;
          default: occ_q <= occ_q;
        endcase
      end
      if (in_fire && in_type == 2'b11) err_q <= 1'b1;
    end
  end

  generate
    if (PIPE_STAGES == 1) begin : g_one
      logic             v_q;
      logic [127:0]     d_q;
      logic [TAG_W-1:0] t_q;
      logic             adv;

      assign adv       = !v_q | out_ready;
      assign in_ready  = run_q & !flush & adv;
      assign out_valid = v_q;
      assign out_data  = d_q;
      assign out_tag   = t_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          d_q <= '0;
          t_q <= '0;
        end else begin
          if (flush)    v_q <= 1'b0;
          else if (adv) v_q <= in_fire;
          if (in_fire) begin
            d_q <= post_fn(pre_fn(in_data, in_type), in_key, in_type[0]);
            t_q <= in_tag;
          end
        end
      end
    end else begin : g_two
      logic             s1_v, s2_v;
      logic [127:0]     s1_d, s1_k, s2_d;
      logic             s1_mix;
      logic [TAG_W-1:0] s1_t, s2_t;
      logic             adv0, adv1;

      // A stage may load when it is empty or its content moves on this edge.
      assign adv1      = !s2_v | out_ready;
      assign adv0      = !s1_v | adv1;
      assign in_ready  = run_q & !flush & adv0;
      assign out_valid = s2_v;
      assign out_data  = s2_d;
      assign out_tag   = s2_t;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_v   <= 1'b0;
          s1_d   <= '0;
          s1_k   <= '0;
          s1_mix <= 1'b0;
          s1_t   <= '0;
          s2_v   <= 1'b0;
          s2_d   <= '0;
          s2_t   <= '0;
        end else begin
          if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
          end else begin
            if (adv1) s2_v <= s1_v;
            if (adv0) s1_v <= in_fire;
          end
          if (adv1 && s1_v) begin
            s2_d <= post_fn(s1_d, s1_k, s1_mix);
            s2_t <= s1_t;
          end
          if (in_fire) begin
            s1_d   <= pre_fn(in_data, in_type);
            s1_k   <= in_key;
            s1_mix <= in_type[0];
            s1_t   <= in_tag;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_aes_round_pipe.sv
// tb_aes_round_pipe
//   Table-driven vectors plus hand-written multi-cycle sequences for
//   aes_round_pipe (default 2 stages). Expected results come from constant
//   vectors and from a reference round model whose S-box is derived from
//   the GF(2^8) inverse and affine map; a queue scoreboard checks order,
//   data and tags of every delivered block.
module tb_aes_round_pipe;
  localparam int PIPE = 2;
  localparam int TW   = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [127:0]   in_key;
  logic [1:0]     in_type;
  logic [TW-1:0]  in_tag;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic [TW-1:0]  out_tag;
  logic [1:0]     occupancy;
  logic           err_type;

  aes_round_pipe #(.PIPE_STAGES(PIPE), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_type(in_type), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .occupancy(occupancy), .err_type(err_type)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int saw;

  typedef struct {
    logic [127:0]  data;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [127:0]  data;
    logic [127:0]  key;
    logic [1:0]    typ;
    logic [TW-1:0] tag;
    logic [127:0]  exp;
  } vec_t;
  vec_t tv [7];

  logic [7:0]    tb_sbox [256];
  logic [127:0]  cur_exp;

  logic          stall_hold = 1'b0;
  logic [127:0]  held_d;
  logic [TW-1:0] held_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0]  inv;
    logic [15:0] w;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      w = {inv, inv};
      tb_sbox[x] = inv ^ w[14:7] ^ w[13:6] ^ w[12:5] ^ w[11:4] ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] d, input logic [127:0] k,
                                               input logic [1:0] t);
    logic [7:0]   a [4][4];
    logic [7:0]   b [4][4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) a[i % 4][i / 4] = d[127 - 8*i -: 8];
    if (t != 2'b00) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          b[r][c] = tb_sbox[a[r][(c + r) % 4]];
      a = b;
    end
    if (t == 2'b01 || t == 2'b11) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          b[r][c] = gmul(8'h02, a[r][c]) ^ gmul(8'h03, a[(r + 1) % 4][c])
                  ^ a[(r + 2) % 4][c] ^ a[(r + 3) % 4][c];
      a = b;
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = a[i % 4][i / 4];
    return res ^ k;
  endfunction

  // Scoreboard / monitor, sampling between active edges.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      stall_hold = 1'b0;
    end else begin
      if (stall_hold) begin
        check("stall_valid", 128'(out_valid), 128'd1);
        check("stall_data", out_data, held_d);
        check("stall_tag", 128'(out_tag), 128'(held_t));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          report_fail("unexpected_out");
        end else begin
          e = sb_q.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_tag", 128'(out_tag), 128'(e.tag));
        end
      end
      stall_hold = out_valid && !out_ready && !flush;
      held_d = out_data;
      held_t = out_tag;
      if (in_valid && in_ready) sb_q.push_back('{data: cur_exp, tag: in_tag});
      if (flush) sb_q.delete();
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic [1:0] t,
                      input logic [TW-1:0] tg, input logic [127:0] e);
    int n = 0;
    in_data  = d;
    in_key   = k;
    in_type  = t;
    in_tag   = tg;
    cur_exp  = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) report_fail("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 128'(sb_q.size()), 128'd0);
    check("drain_occ", 128'(occupancy), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              2'b00, 4'd3, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    tv[1] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'ha0fafe1788542cb123a339392a6c7605,
              2'b01, 4'd5, 128'ha49c7ff2689f352b6b5bea43026a5049};
    tv[2] = '{128'heb40f21e592e38848ba113e71bc342d2, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
              2'b10, 4'd9, 128'h3925841d02dc09fbdc118597196a0b32};
    tv[3] = '{128'h0, 128'h0123456789abcdeffedcba9876543210,
              2'b00, 4'd15, 128'h0123456789abcdeffedcba9876543210};
    tv[4] = '{128'h0, 128'h0, 2'b10, 4'd0, {16{8'h63}}};
    tv[5] = '{128'h0, {16{8'hff}}, 2'b01, 4'd1, {16{8'h9c}}};
    tv[6] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'ha0fafe1788542cb123a339392a6c7605,
              2'b11, 4'd6, 128'ha49c7ff2689f352b6b5bea43026a5049};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_key = '0; in_type = 2'b00; in_tag = '0; cur_exp = '0;
    build_sbox();

    // Reset state
    #2;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_out_tag", 128'(out_tag), 128'd0);
    check("rst_occ", 128'(occupancy), 128'd0);
    check("rst_err", 128'(err_type), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_pre", 128'(in_ready), 128'd0);
    @(negedge clk);
    check("rel_ready_post", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // Vector table, one block at a time
    for (int i = 0; i < 7; i++) begin
      if (i == 6) check("err_before_res", 128'(err_type), 128'd0);
      send(tv[i].data, tv[i].key, tv[i].typ, tv[i].tag,
           model_round(tv[i].data, tv[i].key, tv[i].typ));
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check("latency", 128'(lat), 128'(PIPE));
      check("vec_data", out_data, tv[i].exp);
      check("vec_tag", 128'(out_tag), 128'(tv[i].tag));
      @(posedge clk);
      #1;
    end
    check("err_set", 128'(err_type), 128'd1);
    drain();

    // Random stream with random backpressure
    fork
      begin
        logic [127:0] d, k;
        logic [1:0]   t;
        for (int i = 0; i < 24; i++) begin
          d = {$urandom, $urandom, $urandom, $urandom};
          k = {$urandom, $urandom, $urandom, $urandom};
          t = 2'($urandom_range(0, 3));
          send(d, k, t, TW'($urandom), model_round(d, k, t));
        end
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Back-to-back stream with a 3-cycle output stall
    fork
      begin
        for (int i = 0; i < 3; i++)
          send(tv[i].data, tv[i].key, tv[i].typ, tv[i].tag, tv[i].exp);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("full_occ", 128'(occupancy), 128'(PIPE));
          check("full_in_ready", 128'(in_ready), 128'd0);
          check("full_out_valid", 128'(out_valid), 128'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two blocks in flight and an input offered in the flush cycle
    out_ready = 1'b0;
    send(tv[0].data, tv[0].key, tv[0].typ, tv[0].tag, tv[0].exp);
    send(tv[1].data, tv[1].key, tv[1].typ, tv[1].tag, tv[1].exp);
    in_data = tv[2].data; in_key = tv[2].key; in_type = tv[2].typ; in_tag = tv[2].tag;
    cur_exp = tv[2].exp;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_occ_pre", 128'(occupancy), 128'd2);
    check("flush_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_occ", 128'(occupancy), 128'd0);
    check("flush_out_valid", 128'(out_valid), 128'd0);
    saw = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("flush_no_out", 128'(saw), 128'd0);
    check("flush_err_kept", 128'(err_type), 128'd1);
    @(posedge clk);
    #1;

    // Reset pulse mid-operation
    out_ready = 1'b0;
    send(tv[0].data, tv[0].key, tv[0].typ, tv[0].tag, tv[0].exp);
    send(tv[1].data, tv[1].key, tv[1].typ, tv[1].tag, tv[1].exp);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_out_data", out_data, 128'd0);
    check("mid_rst_occ", 128'(occupancy), 128'd0);
    check("mid_rst_err", 128'(err_type), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rel_ready_pre", 128'(in_ready), 128'd0);
    saw = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("mid_rel_ready_post", 128'(in_ready), 128'd1);
    check("mid_rel_no_out", 128'(saw), 128'd0);
    check("mid_rel_occ", 128'(occupancy), 128'd0);
    @(posedge clk);
    #1;

    // Reserved type after reset sets the flag again and computes as MID
    send(tv[6].data, tv[6].key, tv[6].typ, tv[6].tag, tv[6].exp);
    drain();
    check("err_reset_again", 128'(err_type), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_round_pipe.md
AES_ROUND_PIPE -- requirements
Module: aes_round_pipe

Interface
REQ-001 Parameter PIPE_STAGES, default 2, SHALL select the register stage count; legal values are 1 and 2.
REQ-002 Parameter TAG_W, default 4, SHALL set the width of the sideband tag carried alongside each block.
REQ-003 clk  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 flush  in  1  SHALL be a synchronous clear of all in-flight blocks.
REQ-006 in_valid  in  1  SHALL indicate an input block is offered.
REQ-007 in_ready  out  1  SHALL indicate the block accepts input this cycle.
REQ-008 in_data  in  128  SHALL be the AES state input, byte 0 at [127:120].
REQ-009 in_key  in  128  SHALL be the round key for this block.
REQ-010 in_type  in  2  SHALL be the round type: 00 INIT, 01 MID, 10 FINAL, 11 reserved.
REQ-011 in_tag  in  TAG_W  SHALL be opaque sideband data returned unchanged with the result.
REQ-012 out_valid  out  1  SHALL indicate a result block is presented.
REQ-013 out_ready  in  1  SHALL indicate the consumer accepts the result this cycle.
REQ-014 out_data  out  128  SHALL be the round result.
REQ-015 out_tag  out  TAG_W  SHALL be the tag of the presented result.
REQ-016 occupancy  out  2  SHALL be the count of valid stages, 0..PIPE_STAGES.
REQ-017 err_type  out  1  SHALL be a sticky flag set when a block with in_type=11 is accepted.

Function
REQ-018 Transfer SHALL occur on in_valid&in_ready (input side) and on out_valid&out_ready (output side).
REQ-019 INIT SHALL compute AddRoundKey(in_data, in_key).
REQ-020 MID SHALL compute AddRoundKey(MixColumns(ShiftRows(SubBytes(in_data))), in_key).
REQ-021 FINAL SHALL compute AddRoundKey(ShiftRows(SubBytes(in_data)), in_key).
REQ-022 Reserved type 11 SHALL be computed as MID and SHALL set err_type.
REQ-023 With PIPE_STAGES=2: stage 1 SHALL register the SubBytes+ShiftRows result (or raw in_data for INIT), plus key, type and tag; stage 2 SHALL register the MixColumns/AddRoundKey result.
REQ-024 With PIPE_STAGES=1, the whole round SHALL be computed combinationally into a single register.
REQ-025 Latency from input transfer to out_valid SHALL be exactly PIPE_STAGES cycles when not stalled.
REQ-026 Throughput SHALL be one block per cycle while out_ready=1.
REQ-027 Each stage k SHALL advance when empty or when its downstream consumer takes its content; in_ready = !valid[0] | advance[0].
REQ-028 in_ready MAY depend combinationally on out_ready; no skid buffer is required.
REQ-029 While out_valid=1 and out_ready=0, out_data and out_tag SHALL hold stable and no stage content SHALL be lost or overwritten.
REQ-030 Blocks SHALL exit in acceptance order with their own tags.
REQ-031 occupancy SHALL increment on input-only transfer, decrement on output-only transfer, and be unchanged on simultaneous or no transfer.
REQ-032 flush=1 SHALL clear all stage-valid bits and occupancy at the next edge, force in_ready=0 that cycle, and discard any simultaneous input; err_type is unaffected.
REQ-033 Data registers SHALL NOT need to be cleared on flush; only valid bits and occupancy.

Reset
REQ-034 During rst_n=0: out_valid=0, out_data=0, out_tag=0, occupancy=0, err_type=0, all stage-valid bits=0, in_ready=0.
REQ-035 Reset assertion mid-operation SHALL discard all in-flight blocks; in_ready SHALL go to 1 on the first edge after deassertion.
REQ-036 err_type SHALL clear only on reset.

Verification
REQ-037 INIT, in_data=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, tag=3 -> out_data=193de3bea0f4e22b9ac68d2ae9f84808, out_tag=3, after PIPE_STAGES cycles.
REQ-038 MID, in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_key=a0fafe1788542cb123a339392a6c7605 -> out_data=a49c7ff2689f352b6b5bea43026a5049.
REQ-039 FINAL, in_data=eb40f21e592e38848ba113e71bc342d2, in_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> out_data=3925841d02dc09fbdc118597196a0b32.
REQ-040 Back-to-back stream of the REQ-037..039 vectors with out_ready held low for 3 cycles mid-stream -> occupancy saturates at PIPE_STAGES, in_ready=0 while full, outputs stable, all 3 results delivered in order with matching tags.
REQ-041 Two blocks in flight, flush=1 for one cycle with in_valid=1 -> occupancy=0, no out_valid for those blocks, flush-cycle input is not delivered.
REQ-042 Accept a type=11 block -> err_type=1 and persists; result equals MID; a subsequent rst_n pulse -> err_type=0, occupancy=0.
